// File: rtl/alu_op.sv
// alu_op: ALU control decoder. Combines the main-control class code with the
// R-type function field and registers the 3-bit ALU operation select plus an
// illegal-function flag for the exception logic. One clock of latency.
module alu_op (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] func,
  input  logic [1:0] ALUctr,
  output logic [2:0] ALU_op,
  output logic       illegal
);

  // ALU operation encoding shared with the ALU; 3'b101 is never produced.
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // Class codes from the main control unit.
  localparam logic [1:0] CLS_ADD   = 2'b00;
  localparam logic [1:0] CLS_SUB   = 2'b01;
  localparam logic [1:0] CLS_RTYPE = 2'b10;
  localparam logic [1:0] CLS_OR    = 2'b11;

  // R-type function decode; returns {illegal, op}. Unlisted codes fall back to
  // ADD so the datapath stays well defined while the exception is raised.
  function automatic logic [3:0] decode_func(input logic [5:0] f);
    logic [3:0] res;
    case (f)
      6'b100000, 6'b100001: res = {1'b0, OP_ADD};
      6'b100010, 6'b100011: res = {1'b0, OP_SUB};
      6'b100100:            res = {1'b0, OP_AND};
      6'b100101:            res = {1'b0, OP_OR};
      6'b100110:            res = {1'b0, OP_XOR};
      6'b100111:            res = {1'b0, OP_NOR};
      6'b101010, 6'b101011: res = {1'b0, OP_SLT};
      default:              res = {1'b1, OP_ADD};
    endcase
    return res;
  endfunction

  logic [2:0] op_next_s;
  logic       illegal_next_s;
  logic [3:0] rtype_dec_s;

  // Combinational next-value decode from the class code and function field.
  always_comb begin
    op_next_s      = OP_ADD;
    illegal_next_s = 1'b0;
    rtype_dec_s    = decode_func(func);
    case (ALUctr)
      CLS_ADD: begin
        op_next_s      = OP_ADD;
        illegal_next_s = 1'b0;
      end
      CLS_SUB: begin
        op_next_s      = OP_SUB;
        illegal_next_s = 1'b0;
      end
      CLS_OR: begin
        op_next_s      = OP_OR;
        illegal_next_s = 1'b0;
      end
      CLS_RTYPE: begin
        op_next_s      = rtype_dec_s[2:0];
        illegal_next_s = rtype_dec_s[3];
      end
      default: begin
        op_next_s      = OP_ADD;
        illegal_next_s = 1'b0;
      end
    endcase
  end

  // Output register; reset forces ADD with no exception, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALU_op  <= OP_ADD;
      illegal <= 1'b0;
    end else begin
      ALU_op  <= op_next_s;
      illegal <= illegal_next_s;
    end
  end

endmodule

// File: tb/tb_alu_op.sv
// tb_alu_op: directed-vector bench for alu_op with hand-computed expectations.
module tb_alu_op;

  logic       clk;
  logic       rst;
  logic [5:0] func;
  logic [1:0] ALUctr;
  logic [2:0] ALU_op;
  logic       illegal;

  int n_tests;
  int n_fail;

  alu_op dut (
    .clk     (clk),
    .rst     (rst),
    .func    (func),
    .ALUctr  (ALUctr),
    .ALU_op  (ALU_op),
    .illegal (illegal)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare {illegal, ALU_op} against the expected pair and count the result.
  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got illegal/op=%b/%b, expected %b/%b",
               tag, obs[3], obs[2:0], exp[3], exp[2:0]);
    end
  endtask

  // Apply one input pair on the falling edge, then check just after the next rising edge.
  task automatic step(input string tag, input logic [1:0] ctr, input logic [5:0] fn,
                      input logic [2:0] exp_op, input logic exp_ill);
    @(negedge clk);
    ALUctr = ctr;
    func   = fn;
    @(posedge clk);
    #1;
    check(tag, {illegal, ALU_op}, {exp_ill, exp_op});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    ALUctr  = 2'b01;
    func    = 6'b000000;

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1 check("reset_async", {illegal, ALU_op}, 4'b0_010);
    @(negedge clk);
    check("reset_hold", {illegal, ALU_op}, 4'b0_010);
    rst = 1'b0;
    @(posedge clk);
    #1 check("reset_release", {illegal, ALU_op}, 4'b0_110);

    // R-type sweep.
    step("r_add",  2'b10, 6'b100000, 3'b010, 1'b0);
    step("r_sub",  2'b10, 6'b100010, 3'b110, 1'b0);
    step("r_and",  2'b10, 6'b100100, 3'b000, 1'b0);
    step("r_or",   2'b10, 6'b100101, 3'b001, 1'b0);
    step("r_xor",  2'b10, 6'b100110, 3'b011, 1'b0);

    // Non-R classes ignore func.
    step("c00_add", 2'b00, 6'b100110, 3'b010, 1'b0);
    step("c01_sub", 2'b01, 6'b100110, 3'b110, 1'b0);
    step("c11_or",  2'b11, 6'b100110, 3'b001, 1'b0);

    // Extended R-type.
    step("r_nor",  2'b10, 6'b100111, 3'b100, 1'b0);
    step("r_slt",  2'b10, 6'b101010, 3'b111, 1'b0);
    step("r_addu", 2'b10, 6'b100001, 3'b010, 1'b0);
    step("r_subu", 2'b10, 6'b100011, 3'b110, 1'b0);
    step("r_sltu", 2'b10, 6'b101011, 3'b111, 1'b0);

    // Illegal function, then recovery on a non-R class.
    step("r_illegal",   2'b10, 6'b001000, 3'b010, 1'b1);
    step("illegal_clr", 2'b00, 6'b001000, 3'b010, 1'b0);

    // Input change between edges must not reach the outputs early.
    step("pre_hold", 2'b10, 6'b100100, 3'b000, 1'b0);
    @(negedge clk);
    ALUctr = 2'b11;
    func   = 6'b000000;
    #1 check("mid_cycle_hold", {illegal, ALU_op}, 4'b0_000);
    @(posedge clk);
    #1 check("after_edge", {illegal, ALU_op}, 4'b0_001);

    // Async reset mid-sequence while output is SLT.
    step("pre_reset_slt", 2'b10, 6'b101010, 3'b111, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("reset_mid", {illegal, ALU_op}, 4'b0_010);
    #1 rst = 1'b0;
    #1 check("reset_mid_low", {illegal, ALU_op}, 4'b0_010);
    @(posedge clk);
    #1 check("resume", {illegal, ALU_op}, 4'b0_111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op.md
# alu_op

ALU control decoder for the single-cycle/multicycle MIPS datapath. It sits between the main control unit and the ALU. It combines the 2-bit class code `ALUctr` from the main decoder with the 6-bit R-type `func` field and produces the 3-bit operation select `ALU_op` for the ALU. The output is registered, with an illegal-function flag for the exception logic.

## Interface
Parameters: none.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `func`  input  6  instruction bits [5:0] (R-type function field)
- `ALUctr`  input  2  operation class from main control
- `ALU_op`  output  3  registered ALU operation select
- `illegal`  output  1  registered flag: R-type class with unsupported `func`

## Operation
ALU_op encoding (fixed, shared with the ALU):
- AND = 000
- OR = 001
- ADD = 010
- XOR = 011
- NOR = 100
- SUB = 110
- SLT = 111
- 101 is never produced.

ALUctr decode:
- 00 → ADD (load/store address, addi); `func` ignored.
- 01 → SUB (beq/bne compare); `func` ignored.
- 11 → OR (ori); `func` ignored.
- 10 → R-type; decode `func` as listed below.

R-type `func` decode:
- 100000 add and 100001 addu → ADD
- 100010 sub and 100011 subu → SUB
- 100100 and → AND
- 100101 or → OR
- 100110 xor → XOR
- 100111 nor → NOR
- 101010 slt and 101011 sltu → SLT
- any other `func` → ADD, with `illegal` = 1

`illegal` = 1 only for ALUctr = 10 with an unlisted `func`; otherwise 0.

Decode is purely combinational. The combinational next-value feeds one output register for `ALU_op` and `illegal`. No other state exists.

## Timing
- Reset (`rst` = 1, asynchronous): `ALU_op` = 010 (ADD) and `illegal` = 0 immediately, independent of `clk`. Outputs hold these values while `rst` is high.
- Latency: exactly 1 clock. Inputs sampled at rising edge N appear on the outputs after edge N; they are stable until edge N+1.
- New inputs are accepted every cycle, with no handshake and no stall.
- Input changes between edges have no effect on the outputs until the next rising edge.
- Reset release: the first rising edge with `rst` = 0 loads the decode of the current inputs.
- Reset asserted mid-stream: the pending decode is discarded. Outputs go to reset values at once.
- `ALUctr` and `func` changing in the same cycle: the outputs reflect the pair sampled together at the edge.

## Test plan
- Reset: assert `rst` with ALUctr = 01 → `ALU_op` = 010 and `illegal` = 0 without a clock edge. After release, the next edge gives `ALU_op` = 110.
- R-type sweep, ALUctr = 10, one value per cycle, one-cycle latency, `illegal` = 0 throughout:
  - func 100000 → 010
  - func 100010 → 110
  - func 100100 → 000
  - func 100101 → 001
  - func 100110 → 011
- Non-R classes with func = 100110 held: ALUctr 00 → 010, ALUctr 01 → 110, ALUctr 11 → 001; `func` is ignored.
- Extended R-type: ALUctr = 10, func 100111 → 100; 101010 → 111; 100001 → 010; 100011 → 110.
- Illegal function: ALUctr = 10, func = 001000 → `ALU_op` = 010 and `illegal` = 1. Switching to ALUctr = 00 next cycle → `illegal` = 0.
- Async reset mid-sequence: `rst` pulsed between edges while `ALU_op` = 111 → outputs drop to 010/0 before the next edge. The following edge, with `rst` low, resumes decode.
